tmds_channel_decoder: RTL and testbench

Receive-side counterpart of the DVI transmit path. It takes the raw 10-bit TMDS words from one channel's 1:10 deserializer, aligns them to word boundaries by hunting for control-token runs and pulsing `bitslip`, then decodes each word to 8-bit pixel data or 2-bit control data. Three instances, one per channel (blue, green, red), feed a future DVI receive/loopback path. That path checks the pattern generator's output end to end.

---
 rtl/tmds_pkg.sv | 34 +++
 rtl/tmds_channel_decoder_if.sv | 21 ++
 rtl/tmds_decode_10b8b.sv | 26 ++
 rtl/tmds_channel_decoder.sv | 162 ++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive channel decoder: control tokens,
// the token-to-c1c0 mapping and the alignment FSM state encoding.
package tmds_pkg;

    localparam logic [9:0] TOKEN_00 = 10'h354;
    localparam logic [9:0] TOKEN_01 = 10'h0AB;
    localparam logic [9:0] TOKEN_10 = 10'h154;
    localparam logic [9:0] TOKEN_11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH,
        SLIP,
        WAIT,
        LOCKED
    } state_t;

    function automatic logic is_ctrl_token(input logic [9:0] word);
        return (word == TOKEN_00) || (word == TOKEN_01) ||
               (word == TOKEN_10) || (word == TOKEN_11);
    endfunction

    // Returns {c1, c0}; non-token words map to 00 and are masked by is_ctrl_token.
    function automatic logic [1:0] token_ctrl(input logic [9:0] word);
        logic [1:0] ctrl;
        case (word)
            TOKEN_01: ctrl = 2'b01;
            TOKEN_10: ctrl = 2'b10;
            TOKEN_11: ctrl = 2'b11;
            default:  ctrl = 2'b00;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Word-level bundle between a 1:10 deserializer and one TMDS channel decoder.
// The deserializer side drives words and reacts to bitslip; the decoder drives the rest.
interface tmds_channel_decoder_if;
    logic [9:0] tmdsWord;
    logic       bitslip;
    logic       aligned;
    logic       de;
    logic       c0;
    logic       c1;
    logic [7:0] data;

    modport master (
        output tmdsWord,
        input  bitslip, aligned, de, c0, c1, data
    );

    modport slave (
        input  tmdsWord,
        output bitslip, aligned, de, c0, c1, data
    );
endinterface

// File: rtl/tmds_decode_10b8b.sv
// Combinational TMDS 10b->8b decode with control-token classification.
// The caller registers all outputs.
module tmds_decode_10b8b
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] d;

    // Undo the optional inversion (bit 9) and then the XOR/XNOR chain (bit 8).
    always_comb begin
        is_token = is_ctrl_token(word);
        ctrl     = token_ctrl(word);
        d        = word[9] ? ~word[7:0] : word[7:0];
        data     = '0;
        data[0]  = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment by control-token runs with bitslip,
// followed by a registered 10b->8b decode that is only live while locked.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int MIN_RUN       = 8,
    parameter int LOCK_RUNS     = 4,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SLIP_WAIT     = 8
) (
    input logic               pixelClk,
    input logic               resetn,
    tmds_channel_decoder_if.slave tmds
);

    localparam int RUN_W  = $clog2(MIN_RUN + 1);
    localparam int RUNS_W = $clog2(LOCK_RUNS + 1);
    localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MIN_RUN);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(MIN_RUN - 1);
    localparam logic [RUNS_W-1:0] RUNS_LAST = RUNS_W'(LOCK_RUNS - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    state_t              state_q, state_d;
    logic [9:0]          word_q;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [RUNS_W-1:0]   runs_seen_q, runs_seen_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                de_q, de_d;
    logic [1:0]          c_q, c_d;
    logic [7:0]          data_q, data_d;

    logic                is_token;
    logic [1:0]          tok_ctrl;
    logic [7:0]          dec_data;
    logic                valid_run;

    tmds_decode_10b8b u_decode (
        .word     (word_q),
        .is_token (is_token),
        .ctrl     (tok_ctrl),
        .data     (dec_data)
    );

    // Expiry is tested on the old count so the transition lands on the edge
    // where winCnt would reach SEARCH_WINDOW; a valid run always takes priority.
    always_comb begin
        valid_run   = is_token && (run_cnt_q == RUN_LAST);
        state_d     = state_q;
        runs_seen_d = runs_seen_q;
        win_cnt_d   = win_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (!is_token) begin
            run_cnt_d = '0;
        end else if (run_cnt_q == RUN_MAX) begin
            run_cnt_d = RUN_MAX;
        end else begin
            run_cnt_d = run_cnt_q + 1'b1;
        end

        case (state_q)
            SEARCH: begin
                if (valid_run) begin
                    win_cnt_d   = '0;
                    runs_seen_d = runs_seen_q + 1'b1;
                    if (runs_seen_q == RUNS_LAST) begin
                        state_d = LOCKED;
                    end
                end else if (win_cnt_q == WIN_LAST) begin
                    state_d   = SLIP;
                    win_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                end
            end
            SLIP: begin
                state_d     = WAIT;
                run_cnt_d   = '0;
                runs_seen_d = '0;
                win_cnt_d   = '0;
                wait_cnt_d  = '0;
            end
            WAIT: begin
                run_cnt_d = '0;
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = SEARCH;
                    wait_cnt_d = '0;
                    win_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            LOCKED: begin
                if (valid_run) begin
                    win_cnt_d = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    state_d     = SEARCH;
                    runs_seen_d = '0;
                    win_cnt_d   = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Gating on the next state keeps the decode outputs in step with aligned.
    always_comb begin
        de_d   = 1'b0;
        c_d    = 2'b00;
        data_d = '0;
        if (state_d == LOCKED) begin
            if (is_token) begin
                c_d    = tok_ctrl;
                data_d = data_q;
            end else begin
                de_d   = 1'b1;
                c_d    = c_q;
                data_d = dec_data;
            end
        end
    end

    always_ff @(posedge pixelClk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= SEARCH;
            word_q      <= '0;
            run_cnt_q   <= '0;
            runs_seen_q <= '0;
            win_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            de_q        <= 1'b0;
            c_q         <= 2'b00;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= tmds.tmdsWord;
            run_cnt_q   <= run_cnt_d;
            runs_seen_q <= runs_seen_d;
            win_cnt_q   <= win_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            de_q        <= de_d;
            c_q         <= c_d;
            data_q      <= data_d;
        end
    end

    assign tmds.bitslip = (state_q == SLIP);
    assign tmds.aligned = (state_q == LOCKED);
    assign tmds.de      = de_q;
    assign tmds.c0      = c_q[0];
    assign tmds.c1      = c_q[1];
    assign tmds.data    = data_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: reset, clean lock, decode, loss of
// lock, bitslip recovery from a 3-bit misaligned stream and asynchronous reset.
module tb_tmds_channel_decoder;
    import tmds_pkg::*;

    logic pixelClk = 1'b0;
    logic resetn   = 1'b0;

    tmds_channel_decoder_if tmds ();

    tmds_channel_decoder dut (
        .pixelClk (pixelClk),
        .resetn   (resetn),
        .tmds     (tmds)
    );

    always #5 pixelClk = ~pixelClk;

    int         num_compared   = 0;
    int         num_mismatched = 0;
    int         edge_cnt       = 0;
    int         rot            = 0;
    int         slip_cnt       = 0;
    int         slip_edge [0:7];
    logic [9:0] prev_word      = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Deserializer model: the serial stream is seen through a boundary that is
    // rot bits late; each observed bitslip pulse moves it one bit closer.
    task automatic applyStimulus(input logic [9:0] word);
        logic [19:0] pair;
        pair          = {word, prev_word} >> (10 - rot);
        tmds.tmdsWord = pair[9:0];
        @(posedge pixelClk);
        #1;
        edge_cnt++;
        prev_word = word;
        if (tmds.bitslip === 1'b1) begin
            if (slip_cnt < 8) slip_edge[slip_cnt] = edge_cnt;
            slip_cnt++;
            if (rot > 0) rot--;
        end
    endtask

    function automatic logic [9:0] dataWord(input int i);
        return 10'(32'h100 + (i % 64));
    endfunction

    task automatic resetDut(input int start_rot);
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tmds.tmdsWord = 10'($urandom);
            @(posedge pixelClk);
        end
        #1;
        checkOutput("reset_aligned", tmds.aligned, 0);
        checkOutput("reset_bitslip", tmds.bitslip, 0);
        checkOutput("reset_de", tmds.de, 0);
        checkOutput("reset_c1c0", {tmds.c1, tmds.c0}, 0);
        checkOutput("reset_data", tmds.data, 0);
        @(negedge pixelClk);
        resetn    = 1'b1;
        edge_cnt  = 0;
        slip_cnt  = 0;
        rot       = start_rot;
        prev_word = '0;
    endtask

    logic [9:0] dec_words [0:5];
    logic [10:0] dec_exp  [0:5];
    int         bad_cnt;
    int         lock_edge;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tmds.tmdsWord = '0;

        // Reset, then a full search window of pure data.
        resetDut(0);
        bad_cnt = 0;
        for (int i = 0; i < 4095; i++) begin
            applyStimulus(dataWord(i));
            if (tmds.aligned !== 1'b0) bad_cnt++;
        end
        checkOutput("data_only_no_slip", slip_cnt, 0);
        checkOutput("data_only_no_align", bad_cnt, 0);
        applyStimulus(dataWord(4095));
        checkOutput("window_expiry_slip", tmds.bitslip, 1);

        // Clean lock from four blanking runs.
        resetDut(0);
        bad_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) begin
                applyStimulus(TOKEN_00);
                if (r == 3 && k == 7) checkOutput("lock_edge_E", tmds.aligned, 0);
                else if (r == 3 && k == 8) checkOutput("lock_edge_E1", tmds.aligned, 1);
                else if (r < 3 && tmds.aligned !== 1'b0) bad_cnt++;
            end
            for (int k = 0; k < 100; k++) applyStimulus(dataWord(k));
        end
        checkOutput("lock_early_align", bad_cnt, 0);
        checkOutput("lock_no_slip", slip_cnt, 0);
        checkOutput("lock_held", tmds.aligned, 1);

        // Decode while locked: {de, c1c0, data} two edges after each word is driven.
        dec_words[0] = 10'b0100000000; dec_exp[0] = {1'b1, 2'b00, 8'h00};
        dec_words[1] = 10'b1011111111; dec_exp[1] = {1'b1, 2'b00, 8'hFE};
        dec_words[2] = TOKEN_11;       dec_exp[2] = {1'b0, 2'b11, 8'h00};
        dec_words[3] = TOKEN_01;       dec_exp[3] = {1'b0, 2'b01, 8'h00};
        dec_words[4] = 10'b0111110000; dec_exp[4] = {1'b1, 2'b01, 8'h10};
        dec_words[5] = 10'b1000000000; dec_exp[5] = {1'b1, 2'b01, 8'hFF};
        for (int i = 0; i <= 6; i++) begin
            applyStimulus(i < 6 ? dec_words[i] : dataWord(0));
            if (i > 0) begin
                checkOutput($sformatf("decode_de_%0d", i - 1), tmds.de, dec_exp[i-1][10]);
                checkOutput($sformatf("decode_c1c0_%0d", i - 1), {tmds.c1, tmds.c0},
                            dec_exp[i-1][9:8]);
                if (dec_exp[i-1][10])
                    checkOutput($sformatf("decode_data_%0d", i - 1), tmds.data,
                                dec_exp[i-1][7:0]);
            end
        end

        // Loss of lock: one exact-length run, then data until the window expires.
        for (int k = 0; k < 8; k++) applyStimulus(TOKEN_01);
        bad_cnt  = 0;
        slip_cnt = 0;
        for (int m = 1; m <= 4097; m++) begin
            applyStimulus(dataWord(m));
            if (m == 4096) checkOutput("unlock_still_aligned", tmds.aligned, 1);
            else if (m == 4097) begin
                checkOutput("unlock_aligned_falls", tmds.aligned, 0);
                checkOutput("unlock_de_forced", tmds.de, 0);
                checkOutput("unlock_data_forced", tmds.data, 0);
            end else if (tmds.aligned !== 1'b1) bad_cnt++;
        end
        checkOutput("unlock_early_drop", bad_cnt, 0);
        for (int m = 0; m < 4095; m++) applyStimulus(dataWord(m));
        checkOutput("unlock_no_slip", slip_cnt, 0);
        applyStimulus(dataWord(7));
        checkOutput("unlock_window_slip", tmds.bitslip, 1);

        // Misaligned start: stream rotated by 3 bits.
        resetDut(3);
        for (int p = 0; p < 20000 && tmds.aligned !== 1'b1; p++) begin
            applyStimulus((p % 116) < 16 ? TOKEN_00 : dataWord(p));
        end
        lock_edge = edge_cnt;
        checkOutput("misalign_lock", tmds.aligned, 1);
        checkOutput("misalign_slip_count", slip_cnt, 3);
        checkOutput("misalign_rotation", rot, 0);
        checkOutput("misalign_first_slip", slip_edge[0], 4096);
        checkOutput("misalign_gap_1", (slip_edge[1] - slip_edge[0]) >= 4096, 1);
        checkOutput("misalign_gap_2", (slip_edge[2] - slip_edge[1]) >= 4096, 1);
        for (int k = 0; k < 10; k++) applyStimulus(dataWord(k));
        checkOutput("misalign_no_extra_slip", slip_cnt, 3);
        checkOutput("misalign_de", tmds.de, 1);

        // Asynchronous reset mid-cycle while decoding data.
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_reset_aligned", tmds.aligned, 0);
        checkOutput("async_reset_de", tmds.de, 0);
        checkOutput("async_reset_bitslip", tmds.bitslip, 0);
        @(negedge pixelClk);
        resetn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
